cache_mem_arbiter: RTL

//   Arbitrates the single main-memory port between the instruction-cache refill

---
 rtl/cache_mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache and D-cache refill/writeback.
// Latency: req in IDLE -> gnt next cycle -> done one cycle after mem_ack (or after TIMEOUT BUSY cycles); requesters hold req until done.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_gnt,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_ic,
  output logic              stall_dc,
  output logic              timeout,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_ic,
  output logic [CNT_W-1:0]  cnt_dc,
  output logic [CNT_W-1:0]  cnt_wait
);

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sel;      // 0 = IC, 1 = DC
  logic              r_rr_last;
  logic              r_ic_gnt;
  logic              r_dc_gnt;
  logic [WC_W-1:0]   r_wcnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_ic_rdata;
  logic [LINE_W-1:0] r_dc_rdata;
  logic [CNT_W-1:0]  r_cnt_ic;
  logic [CNT_W-1:0]  r_cnt_dc;
  logic [CNT_W-1:0]  r_cnt_wait;

  logic w_any_req;
  logic w_sel;
  logic w_timeout;
  logic w_ic_done;
  logic w_dc_done;
  logic w_other_wait;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_any_req    = ic_req | dc_req;
    // On contention the requester that was not served last wins.
    w_sel        = (ic_req && dc_req) ? ~r_rr_last : dc_req;
    w_timeout    = (r_state == S_BUSY) && !mem_ack && (r_wcnt == WC_LAST);
    w_ic_done    = (r_state == S_RESP) && !r_sel;
    w_dc_done    = (r_state == S_RESP) && r_sel;
    w_other_wait = ((r_state == S_BUSY) || (r_state == S_RESP)) &&
                   (r_sel ? ic_req : dc_req);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
      S_BUSY:  if (mem_ack || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_rr_last   <= 1'b0;
      r_ic_gnt    <= 1'b0;
      r_dc_gnt    <= 1'b0;
      r_wcnt      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ic_gnt <= 1'b0;
      r_dc_gnt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel       <= w_sel;
            r_rr_last   <= w_sel;
            r_ic_gnt    <= ~w_sel;
            r_dc_gnt    <= w_sel;
            r_wcnt      <= '0;
            r_mem_we    <= w_sel & dc_we;
            r_mem_addr  <= w_sel ? dc_addr : ic_addr;
            r_mem_wdata <= w_sel ? dc_wdata : '0;
          end
        end
        S_BUSY: begin
          r_wcnt <= r_wcnt + WC_W'(1);
          // A DC writeback still takes the ack but must not disturb dc_rdata.
          if (mem_ack) begin
            if (!r_sel)
              r_ic_rdata <= mem_rdata;
            else if (!r_mem_we)
              r_dc_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_ic   <= '0;
      r_cnt_dc   <= '0;
      r_cnt_wait <= '0;
    end else if (clr_cnt) begin
      r_cnt_ic   <= '0;
      r_cnt_dc   <= '0;
      r_cnt_wait <= '0;
    end else begin
      if (r_ic_gnt)     r_cnt_ic   <= sat_inc(r_cnt_ic);
      if (r_dc_gnt)     r_cnt_dc   <= sat_inc(r_cnt_dc);
      if (w_other_wait) r_cnt_wait <= sat_inc(r_cnt_wait);
    end
  end

  assign ic_gnt    = r_ic_gnt;
  assign dc_gnt    = r_dc_gnt;
  assign ic_done   = w_ic_done;
  assign dc_done   = w_dc_done;
  assign ic_rdata  = r_ic_rdata;
  assign dc_rdata  = r_dc_rdata;
  assign mem_req   = (r_state == S_BUSY);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall_ic  = ic_req & ~w_ic_done;
  assign stall_dc  = dc_req & ~w_dc_done;
  assign timeout   = w_timeout;
  assign cnt_ic    = r_cnt_ic;
  assign cnt_dc    = r_cnt_dc;
  assign cnt_wait  = r_cnt_wait;

endmodule
